square_wave_period_detector: RTL and testbench
==============================================

Name: square_wave_period_detector

Overview:
Consumer-side companion to the discrete square-wave oscillator models. It samples a 16-bit unsigned audio stream on each audio_clk_en strobe and slices it into a logic level using hysteresis thresholds. It then measures period and high time in sample counts, rising edge to rising edge. Used in-fabric to verify oscillator frequency/duty and to drive frequency-dependent logic.

Parameters:
CLOCK_RATE, 48000, audio sample rate in Hz (informational; no arithmetic depends on it)
HIGH_THRESHOLD, 16'd40000, input >= this sets level to 1
LOW_THRESHOLD, 16'd24000, input <= this sets level to 0; must be < HIGH_THRESHOLD
CNT_WIDTH, 20, width of sample counters and measurement outputs
TIMEOUT_SAMPLES, 48000, samples since last rise before lock is dropped; must be < 2^CNT_WIDTH

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
audio_clk_en  in  1  sample strobe; all state advances only on cycles where this is 1
in  in  16  unsigned audio sample
period  out  CNT_WIDTH  last measured period in samples
high_time  out  CNT_WIDTH  high samples within that period
period_valid  out  1  one-cycle pulse when period/high_time update
level  out  1  current hysteresis-sliced level
locked  out  1  1 after the first complete period; cleared on timeout
timeout  out  1  one-cycle pulse when lock is lost

Behaviour:
- Reset (reset_n=0 at a clk edge): period=0, high_time=0, period_valid=0, level=0, locked=0, timeout=0, cnt=0, state=SEEK. Reset overrides audio_clk_en, including mid-measurement.
- All registers update only on enabled cycles (audio_clk_en=1), except period_valid and timeout. Those two are forced to 0 on any cycle without an event, so they are strictly one clk wide.
- Slicer, per enabled sample:
  - in>=HIGH_THRESHOLD -> lvl_next=1
  - in<=LOW_THRESHOLD -> lvl_next=0
  - otherwise lvl_next=level
  - level<=lvl_next.
- Rise = level==0 && lvl_next==1; fall = level==1 && lvl_next==0. Evaluated on the same enabled sample.
- States: SEEK, HIGH, LOW.
  - SEEK: no counting. On rise -> HIGH, cnt<=1.
  - HIGH: cnt<=cnt+1. On fall -> LOW, hi_latch<=cnt (samples from rise sample inclusive to fall sample exclusive); cnt still increments.
  - LOW: cnt<=cnt+1. On rise -> publish period<=cnt and high_time<=hi_latch, then period_valid=1 and locked=1 on the next clk, cnt<=1, -> HIGH.
- First rise after reset or timeout does not produce period_valid. The first valid comes on the second rise.
- Latency: outputs and pulse appear on the clk edge that registers the rising sample, i.e. 1 clk after that sample is presented.
- Timeout: in HIGH or LOW, an enabled sample with no rise while cnt==TIMEOUT_SAMPLES-1 triggers the following on that edge:
  - timeout=1, locked=0, state->SEEK, cnt<=0
  - period and high_time hold their last values.
- A rise on that same sample takes priority: normal publish, no timeout.
- In SEEK there is no timeout. cnt never wraps, because of the timeout.
- A full period of identical samples cannot produce edges, so period>=2 whenever valid.

Test Plan:
- Reset then 3x16'hFFFF, 3x16'h0000 repeated, audio_clk_en=1 every cycle -> first period_valid on the 2nd rise with period=6, high_time=3, locked=1; thereafter one pulse every 6 samples with the same values.
- Duty: 5x16'hFFFF, 11x16'h0000 repeated -> period=16, high_time=5 on every pulse after the first.
- Hysteresis: low level 16'h0000, high level 16'hFFFF, with 16'd32768 samples inserted mid-high and mid-low in a 4/4 pattern -> level unchanged by the inserts, period=8, high_time=4. Samples of 16'd30000 never cause a rise from 0.
- Strobe gating: audio_clk_en=1 every 3rd clk, 3/3 pattern held for 3 clks per sample -> period=6, high_time=3, pulses 1 clk wide, spaced 18 clks apart.
- Timeout with TIMEOUT_SAMPLES=100: lock on a 3/3 pattern, then hold 16'hFFFF -> timeout pulse on the 100th sample counted from the last rise (rise=1), locked=0, period stays 6. Resuming the pattern gives the next period_valid only on the 2nd rise.
- Reset mid-period: assert reset_n=0 for 1 clk during the LOW phase of a locked 3/3 stream -> all outputs 0 next clk. The first valid after release is the 2nd post-reset rise, with period=6.

Source files
------------

// File: rtl/square_wave_period_detector.sv
// Hysteresis slicer plus rise-to-rise period / high-time meter for a sampled audio stream.
// All state advances on audio_clk_en; period_valid and timeout are single-clk pulses.
module square_wave_period_detector #(
  parameter int unsigned CLOCK_RATE      = 48000,
  parameter logic [15:0] HIGH_THRESHOLD  = 16'd40000,
  parameter logic [15:0] LOW_THRESHOLD   = 16'd24000,
  parameter int unsigned CNT_WIDTH       = 20,
  parameter int unsigned TIMEOUT_SAMPLES = 48000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 audio_clk_en,
  input  logic [15:0]          in,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 period_valid,
  output logic                 level,
  output logic                 locked,
  output logic                 timeout
);

  if (LOW_THRESHOLD >= HIGH_THRESHOLD || CLOCK_RATE == 0 || TIMEOUT_SAMPLES < 2 ||
      longint'(TIMEOUT_SAMPLES) >= (64'd1 << CNT_WIDTH)) begin : g_bad_params
    $error("square_wave_period_detector: inconsistent parameters");
  end

  localparam logic [CNT_WIDTH-1:0] TimeoutLast = CNT_WIDTH'(TIMEOUT_SAMPLES - 1);
  localparam logic [CNT_WIDTH-1:0] CntOne      = CNT_WIDTH'(1);

  typedef enum logic [1:0] {StSeek, StHigh, StLow} state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] hi_latch_q, hi_latch_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [CNT_WIDTH-1:0] high_time_q, high_time_d;
  logic                 level_q, lvl_next;
  logic                 locked_q, locked_d;
  logic                 valid_q, valid_d;
  logic                 timeout_q, timeout_d;
  logic                 rise, fall, expire;

  always_comb begin
    lvl_next = level_q;
    if (in >= HIGH_THRESHOLD) begin
      lvl_next = 1'b1;
    end else if (in <= LOW_THRESHOLD) begin
      lvl_next = 1'b0;
    end
  end

  assign rise = ~level_q & lvl_next;
  assign fall = level_q & ~lvl_next;
  // A rise on the last permitted sample wins over the timeout.
  assign expire = (state_q != StSeek) && !rise && (cnt_q == TimeoutLast);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StSeek;
      cnt_q       <= '0;
      hi_latch_q  <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      level_q     <= 1'b0;
      locked_q    <= 1'b0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_latch_q  <= hi_latch_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      level_q     <= audio_clk_en ? lvl_next : level_q;
      locked_q    <= locked_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (audio_clk_en) begin
      unique case (state_q)
        StSeek:  if (rise) state_d = StHigh;
        StHigh:  if (expire) state_d = StSeek; else if (fall) state_d = StLow;
        StLow:   if (expire) state_d = StSeek; else if (rise) state_d = StHigh;
        default: state_d = StSeek;
      endcase
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    hi_latch_d  = hi_latch_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    locked_d    = locked_q;
    valid_d     = 1'b0;
    timeout_d   = 1'b0;
    if (audio_clk_en) begin
      if (state_q == StSeek) begin
        if (rise) cnt_d = CntOne;
      end else if (expire) begin
        timeout_d = 1'b1;
        locked_d  = 1'b0;
        cnt_d     = '0;
      end else if (state_q == StLow && rise) begin
        period_d    = cnt_q;
        high_time_d = hi_latch_q;
        valid_d     = 1'b1;
        locked_d    = 1'b1;
        cnt_d       = CntOne;
      end else begin
        cnt_d = cnt_q + CntOne;
        // Count so far covers rise sample inclusive to fall sample exclusive.
        if (state_q == StHigh && fall) hi_latch_d = cnt_q;
      end
    end
  end

  assign period       = period_q;
  assign high_time    = high_time_q;
  assign period_valid = valid_q;
  assign level        = level_q;
  assign locked       = locked_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_square_wave_period_detector.sv
// Scoreboard bench: a sample-index model predicts pulses, level and lock; a monitor checks them.
module tb_square_wave_period_detector;

  localparam int HI_TH = 40000;
  localparam int LO_TH = 24000;
  localparam int TO    = 100;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        audio_clk_en = 1'b0;
  logic [15:0] in_s = 16'h0000;
  logic [19:0] period, high_time;
  logic        period_valid, level, locked, timeout;

  square_wave_period_detector #(
    .CLOCK_RATE(48000), .HIGH_THRESHOLD(16'd40000), .LOW_THRESHOLD(16'd24000),
    .CNT_WIDTH(20), .TIMEOUT_SAMPLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .audio_clk_en(audio_clk_en), .in(in_s),
    .period(period), .high_time(high_time), .period_valid(period_valid),
    .level(level), .locked(locked), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct { bit tmo; int per; int hi; int cyc; } ev_t;
  typedef struct { bit lvl; bit lck; } smp_t;

  ev_t  evq[$];
  smp_t smq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic en_seen = 1'b0;

  // Model: everything in terms of absolute sample indices.
  int n = 0, rise_n = 0, fall_n = 0, m_per = 0, m_hi = 0;
  bit m_lvl = 0, m_meas = 0, m_lck = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_lvl = 0; m_meas = 0; m_lck = 0; m_per = 0; m_hi = 0;
  endtask

  task automatic model_step(input int s);
    bit nl = m_lvl;
    bit r, f;
    ev_t e;
    smp_t sm;
    n++;
    if (s >= HI_TH) nl = 1; else if (s <= LO_TH) nl = 0;
    r = !m_lvl && nl;
    f = m_lvl && !nl;
    if (m_meas && !r && (n - rise_n) == TO - 1) begin
      m_meas = 0; m_lck = 0;
      e = '{tmo: 1, per: m_per, hi: m_hi, cyc: cyc + 1};
      evq.push_back(e);
    end else if (r) begin
      if (m_meas) begin
        m_per = n - rise_n; m_hi = fall_n - rise_n; m_lck = 1;
        e = '{tmo: 0, per: m_per, hi: m_hi, cyc: cyc + 1};
        evq.push_back(e);
      end
      m_meas = 1; rise_n = n;
    end else if (f && m_meas) begin
      fall_n = n;
    end
    m_lvl = nl;
    sm = '{lvl: nl, lck: m_lck};
    smq.push_back(sm);
  endtask

  // One sample held for 'hold' clks, strobed on the last of them.
  task automatic send(input int s, input int hold);
    for (int k = 0; k < hold; k++) begin
      in_s = 16'(s);
      audio_clk_en = (k == hold - 1);
      if (audio_clk_en) model_step(s);
      @(posedge clk); #1;
    end
    audio_clk_en = 1'b0;
  endtask

  task automatic run_sq(input int hi_v, input int lo_v, input int nh, input int nl,
                        input int reps, input int hold);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < nh; i++) send(hi_v, hold);
      for (int i = 0; i < nl; i++) send(lo_v, hold);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; audio_clk_en = 1'b1; in_s = 16'hFFFF;
    @(posedge clk); #1;
    reset_n = 1'b1; audio_clk_en = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_period", 32'(period), 0);
    chk("rst_high_time", 32'(high_time), 0);
    chk("rst_valid", 32'(period_valid), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_timeout", 32'(timeout), 0);
    @(posedge clk); #1;
  endtask

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    en_seen <= audio_clk_en & reset_n;
  end

  always @(negedge clk) begin
    smp_t sm;
    ev_t  e;
    if (en_seen) begin
      if (smq.size() == 0) chk("sample_queue_underflow", 1, 0);
      else begin
        sm = smq.pop_front();
        chk("level", 32'(level), 32'(sm.lvl));
        chk("locked", 32'(locked), 32'(sm.lck));
      end
    end
    if (period_valid || timeout) begin
      if (evq.size() == 0) chk("unexpected_pulse", 32'({period_valid, timeout}), 0);
      else begin
        e = evq.pop_front();
        chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
        chk("period_valid", 32'(period_valid), 32'(!e.tmo));
        chk("timeout", 32'(timeout), 32'(e.tmo));
        chk("period", 32'(period), 32'(e.per));
        chk("high_time", 32'(high_time), 32'(e.hi));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hv, lv, nh, nl, hold;
    @(posedge clk); #1;
    do_reset();
    run_sq(16'hFFFF, 16'h0000, 3, 3, 5, 1);
    run_sq(16'hFFFF, 16'h0000, 5, 11, 4, 1);
    // Hysteresis: mid-band inserts must not move the level.
    for (int r = 0; r < 4; r++) begin
      send(16'hFFFF, 1); send(16'hFFFF, 1); send(32768, 1); send(16'hFFFF, 1);
      send(16'h0000, 1); send(32768, 1); send(16'h0000, 1); send(16'h0000, 1);
    end
    for (int i = 0; i < 6; i++) send(30000, 1);
    run_sq(16'hFFFF, 16'h0000, 3, 3, 4, 3);
    // Lock, then stall high long enough to time out, then resume.
    run_sq(16'hFFFF, 16'h0000, 3, 3, 3, 1);
    for (int i = 0; i < TO + 10; i++) send(16'hFFFF, 1);
    run_sq(16'hFFFF, 16'h0000, 3, 3, 4, 1);
    // Rise exactly on the last permitted sample beats the timeout.
    send(16'hFFFF, 1);
    for (int i = 0; i < TO - 3; i++) send(16'hFFFF, 1);
    send(16'h0000, 1);
    send(16'hFFFF, 1);
    run_sq(16'hFFFF, 16'h0000, 3, 3, 2, 1);
    // Reset during the low phase of a locked stream.
    run_sq(16'hFFFF, 16'h0000, 3, 3, 3, 1);
    send(16'hFFFF, 1); send(16'hFFFF, 1); send(16'hFFFF, 1); send(16'h0000, 1);
    do_reset();
    run_sq(16'hFFFF, 16'h0000, 3, 3, 4, 1);
    // Random bands, noise, run lengths and strobe spacing.
    for (int r = 0; r < 60; r++) begin
      nh = $urandom_range(8, 1);
      nl = $urandom_range(8, 1);
      for (int i = 0; i < nh; i++) begin
        hv = ($urandom_range(4, 0) == 0) ? $urandom_range(39999, 24001) : $urandom_range(65535, 40000);
        hold = $urandom_range(3, 1);
        send(hv, hold);
      end
      for (int i = 0; i < nl; i++) begin
        lv = ($urandom_range(4, 0) == 0) ? $urandom_range(39999, 24001) : $urandom_range(24000, 0);
        hold = $urandom_range(3, 1);
        send(lv, hold);
      end
      if (r == 30) for (int i = 0; i < TO + 5; i++) send($urandom_range(24000, 0), 1);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    chk("events_left", 32'(evq.size()), 0);
    chk("samples_left", 32'(smq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
